// File: rtl/sc_scbc_irqc.sv
// UPC interrupt capture/controller in the SYSCLK domain: glitch filter, edge/level event
// detection, sticky status with hold-off after clear, overrun flag and saturating event count.
module sc_scbc_irqc #(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned HOLD_CYC = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             SYSCLK,
    input  logic             SYSRSTB,
    input  logic             UPC_ISR_SYSCLK,
    input  logic             IRQ_MODE,
    input  logic             IRQ_ENB,
    input  logic             STS_CLR,
    input  logic             CNT_CLR,
    output logic             IRQ_STS,
    output logic             IRQ_OVF,
    output logic             IRQ,
    output logic [CNT_W-1:0] EVCNT
);

    localparam logic [7:0]       FCNT_LAST = 8'(FILT_LEN - 1);
    localparam logic [15:0]      HOLD_LOAD = (HOLD_CYC > 0) ? 16'(HOLD_CYC - 1) : 16'd0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    logic             flt_reg, flt_next;
    logic             flt_d_reg;
    logic [7:0]       fcnt_reg, fcnt_next;
    state_t           state_reg, state_next;
    logic [15:0]      hold_cnt_reg, hold_cnt_next;
    logic             hold_pend_reg, hold_pend_next;
    logic             ovf_reg, ovf_next;
    logic [CNT_W-1:0] evcnt_reg, evcnt_next;
    logic             ev;
    logic             edge_ev;
    logic             count_ev;

    // The filtered level only follows the input after FILT_LEN consecutive differing samples.
    always_comb begin
        flt_next  = flt_reg;
        fcnt_next = 8'd0;
        if (UPC_ISR_SYSCLK != flt_reg) begin
            if (fcnt_reg == FCNT_LAST) begin
                flt_next  = UPC_ISR_SYSCLK;
                fcnt_next = 8'd0;
            end else begin
                fcnt_next = fcnt_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            flt_reg   <= 1'b0;
            flt_d_reg <= 1'b0;
            fcnt_reg  <= 8'd0;
        end else begin
            flt_reg   <= flt_next;
            flt_d_reg <= flt_reg;
            fcnt_reg  <= fcnt_next;
        end
    end

    assign ev      = IRQ_MODE ? flt_reg : (flt_reg & ~flt_d_reg);
    assign edge_ev = ev & ~IRQ_MODE;

    always_comb begin
        state_next     = state_reg;
        hold_cnt_next  = hold_cnt_reg;
        hold_pend_next = hold_pend_reg;
        ovf_next       = ovf_reg;
        count_ev       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // A new event beats a simultaneous clear.
                if (ev) begin
                    state_next = ST_PEND;
                    count_ev   = 1'b1;
                end else if (STS_CLR) begin
                    ovf_next = 1'b0;
                end
            end
            ST_PEND: begin
                if (STS_CLR) begin
                    ovf_next = 1'b0;
                    if (edge_ev) begin
                        count_ev = 1'b1;
                    end else begin
                        state_next     = (HOLD_CYC > 0) ? ST_HOLD : ST_IDLE;
                        hold_cnt_next  = HOLD_LOAD;
                        hold_pend_next = 1'b0;
                    end
                end else if (edge_ev) begin
                    // Edge lost while already pending: counted, but flagged as overrun.
                    count_ev = 1'b1;
                    ovf_next = 1'b1;
                end
            end
            ST_HOLD: begin
                if (STS_CLR) begin
                    ovf_next = 1'b0;
                end
                if (edge_ev) begin
                    count_ev = 1'b1;
                    if (hold_pend_reg) begin
                        ovf_next = 1'b1;
                    end else begin
                        hold_pend_next = 1'b1;
                    end
                end
                if (hold_cnt_reg == 16'd0) begin
                    hold_pend_next = 1'b0;
                    if (hold_pend_reg || ev) begin
                        state_next = ST_PEND;
                        // Level events are only accepted at the end of the window.
                        if (IRQ_MODE) begin
                            count_ev = 1'b1;
                        end
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    hold_cnt_next = hold_cnt_reg - 16'd1;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                hold_pend_next = 1'b0;
            end
        endcase
    end

    always_comb begin
        evcnt_next = evcnt_reg;
        if (CNT_CLR) begin
            evcnt_next = count_ev ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (count_ev && (evcnt_reg != CNT_MAX)) begin
            evcnt_next = evcnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            state_reg     <= ST_IDLE;
            hold_cnt_reg  <= 16'd0;
            hold_pend_reg <= 1'b0;
            ovf_reg       <= 1'b0;
            evcnt_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            hold_cnt_reg  <= hold_cnt_next;
            hold_pend_reg <= hold_pend_next;
            ovf_reg       <= ovf_next;
            evcnt_reg     <= evcnt_next;
        end
    end

    assign IRQ_STS = (state_reg == ST_PEND);
    assign IRQ_OVF = ovf_reg;
    assign IRQ     = IRQ_STS & IRQ_ENB;
    assign EVCNT   = evcnt_reg;

endmodule
